// File: rtl/key_debounce.sv
// Key debouncer: 2-flop synchroniser, FSM glitch filter, clean level plus press/release strobes.
// Defining KEY_LONG_PRESS_EN adds the key_long strobe and its hold-time counter.
module key_debounce #(
    parameter int   CNT_MAX      = 1_000_000,
    parameter logic ACTIVE_LEVEL = 1'b1,
    parameter int   LONG_MAX     = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_value,
    output logic key_press,
    output logic key_release
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic key_long
`endif
);

    // state           | meaning
    // ST_IDLE         | released and stable, waiting for the active level
    // ST_PRESS_WAIT   | active level seen, must hold for CNT_MAX cycles
    // ST_PRESSED      | debounced press, waiting for the inactive level
    // ST_RELEASE_WAIT | inactive level seen, must hold for CNT_MAX cycles
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam int            CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    if (CNT_MAX < 1 || LONG_MAX < 1) begin : g_bad_param
        $error("key_debounce: CNT_MAX and LONG_MAX must be >= 1");
    end

    logic [1:0]    sync_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_value_q, key_value_d;
    logic          key_press_q, key_press_d;
    logic          key_release_q, key_release_d;
    logic          key_act;

    assign key_act = (sync_q[1] == ACTIVE_LEVEL);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_value_d   = key_value_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_act) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!key_act) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_PRESSED;
                    cnt_d       = '0;
                    key_value_d = 1'b1;
                    key_press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!key_act) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (key_act) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    key_value_d   = 1'b0;
                    key_release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q        <= {2{~ACTIVE_LEVEL}};
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            key_value_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], key_in};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_value_q   <= key_value_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_value   = key_value_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_MAX + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);

    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          key_long_q, key_long_d;
    logic          held;
    logic          entry;

    // Entry is the first PRESSED cycle after a debounced press; a bounce back
    // from RELEASE_WAIT belongs to the same press and keeps the count.
    always_comb begin
        held       = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
        entry      = (state_q == ST_PRESSED) && key_press_q;
        long_cnt_d = '0;
        if (held && !entry && !key_release_d) begin
            long_cnt_d = (long_cnt_q == LONG_LAST) ? long_cnt_q : long_cnt_q + LW'(1);
        end
        key_long_d = held && !key_release_d && (long_cnt_d == LONG_LAST)
                     && (entry || (long_cnt_q != LONG_LAST));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            long_cnt_q <= '0;
            key_long_q <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            key_long_q <= key_long_d;
        end
    end

    assign key_long = key_long_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: CNT_MAX=4, LONG_MAX=10, both ACTIVE_LEVEL polarities.
// Long-press steps are included when KEY_LONG_PRESS_EN is defined.
module tb_key_debounce;

    logic sys_clk;
    logic sys_rst_n;
    logic key_a, key_b;
    logic value_a, press_a, release_a;
    logic value_b, press_b, release_b;
`ifdef KEY_LONG_PRESS_EN
    logic long_a, long_b;
`endif

    int n_checks = 0;
    int n_passed = 0;
    int np_a = 0, nr_a = 0, nl_a = 0, viol = 0;
    logic prev_pa = 1'b0, prev_ra = 1'b0, prev_pb = 1'b0, prev_rb = 1'b0;
    int p0, r0, l0;

    key_debounce #(.CNT_MAX(4), .ACTIVE_LEVEL(1'b1), .LONG_MAX(10)) dut_a (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_a),
        .key_value   (value_a),
        .key_press   (press_a),
        .key_release (release_a)
`ifdef KEY_LONG_PRESS_EN
        ,
        .key_long    (long_a)
`endif
    );

    key_debounce #(.CNT_MAX(4), .ACTIVE_LEVEL(1'b0), .LONG_MAX(10)) dut_b (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_b),
        .key_value   (value_b),
        .key_press   (press_b),
        .key_release (release_b)
`ifdef KEY_LONG_PRESS_EN
        ,
        .key_long    (long_b)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Strobe bookkeeping and strobe-shape invariants, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (press_a)   np_a <= np_a + 1;
        if (release_a) nr_a <= nr_a + 1;
`ifdef KEY_LONG_PRESS_EN
        if (long_a)    nl_a <= nl_a + 1;
`endif
        if ((press_a && release_a) || (press_a && prev_pa) || (release_a && prev_ra)) viol <= viol + 1;
        if ((press_b && release_b) || (press_b && prev_pb) || (release_b && prev_rb)) viol <= viol + 1;
        prev_pa <= press_a;
        prev_ra <= release_a;
        prev_pb <= press_b;
        prev_rb <= release_b;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_a     = 1'b0;
        key_b     = 1'b1;
        tick(3);
        chk1("rst_value_a",   value_a,   1'b0);
        chk1("rst_press_a",   press_a,   1'b0);
        chk1("rst_release_a", release_a, 1'b0);
        chk1("rst_value_b",   value_b,   1'b0);
        chk1("rst_press_b",   press_b,   1'b0);
        chk1("rst_release_b", release_b, 1'b0);
`ifdef KEY_LONG_PRESS_EN
        chk1("rst_long_a", long_a, 1'b0);
`endif
        sys_rst_n = 1'b1;
        tick(3);

        // Clean press: strobe on edge 7 only.
        p0 = np_a; r0 = nr_a;
        key_a = 1'b1;
        tick(6);
        chk1("press_e6_value", value_a, 1'b0);
        chk1("press_e6_press", press_a, 1'b0);
        tick(1);
        chk1("press_e7_value", value_a, 1'b1);
        chk1("press_e7_press", press_a, 1'b1);
        tick(1);
        chk1("press_e8_press", press_a, 1'b0);
        chk1("press_e8_value", value_a, 1'b1);

        // Two-cycle release glitch is absorbed, then a real release.
        key_a = 1'b0;
        tick(2);
        key_a = 1'b1;
        tick(10);
        chk1("glitch_rel_value", value_a, 1'b1);
        chkn("glitch_rel_nrel", nr_a - r0, 0);
        key_a = 1'b0;
        tick(6);
        chk1("rel_e6_release", release_a, 1'b0);
        chk1("rel_e6_value",   value_a,   1'b1);
        tick(1);
        chk1("rel_e7_release", release_a, 1'b1);
        chk1("rel_e7_value",   value_a,   1'b0);
        tick(1);
        chk1("rel_e8_release", release_a, 1'b0);
        chkn("cycle1_npress", np_a - p0, 1);
        chkn("cycle1_nrel",   nr_a - r0, 1);

        // Three-cycle bounce on press is rejected.
        p0 = np_a;
        key_a = 1'b1;
        tick(3);
        key_a = 1'b0;
        tick(10);
        chk1("bounce_value", value_a, 1'b0);
        chkn("bounce_npress", np_a - p0, 0);

        // Active-low instance.
        key_b = 1'b0;
        tick(6);
        chk1("alow_e6_value", value_b, 1'b0);
        tick(1);
        chk1("alow_e7_press", press_b, 1'b1);
        chk1("alow_e7_value", value_b, 1'b1);
        tick(1);
        chk1("alow_e8_press", press_b, 1'b0);
        key_b = 1'b1;
        tick(6);
        chk1("alow_rel_e6", release_b, 1'b0);
        tick(1);
        chk1("alow_rel_e7",   release_b, 1'b1);
        chk1("alow_rel_value", value_b,  1'b0);
        tick(1);

`ifdef KEY_LONG_PRESS_EN
        // key_long 10 cycles after key_press, once per press.
        l0 = nl_a;
        key_a = 1'b1;
        tick(7);
        chk1("long1_press", press_a, 1'b1);
        tick(9);
        chk1("long1_e16", long_a, 1'b0);
        tick(1);
        chk1("long1_e17", long_a, 1'b1);
        tick(1);
        chk1("long1_e18", long_a, 1'b0);
        tick(12);
        chkn("long1_count", nl_a - l0, 1);
        key_a = 1'b0;
        tick(7);
        chk1("long1_release", release_a, 1'b1);
        tick(1);
        key_a = 1'b1;
        tick(7);
        chk1("long2_press", press_a, 1'b1);
        tick(9);
        chk1("long2_e16", long_a, 1'b0);
        tick(1);
        chk1("long2_e17", long_a, 1'b1);
        tick(1);
        chk1("long2_e18", long_a, 1'b0);
        key_a = 1'b0;
        tick(10);
        chkn("long2_count", nl_a - l0, 2);
        chk1("long2_idle_value", value_a, 1'b0);
`endif

        // Reset mid PRESS_WAIT, key low afterwards: no strobes.
        p0 = np_a; r0 = nr_a;
        key_a = 1'b1;
        tick(4);
        #2 sys_rst_n = 1'b0;
        #1;
        chk1("rstpw_value", value_a, 1'b0);
        chk1("rstpw_press", press_a, 1'b0);
        key_a = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        tick(12);
        chkn("rstpw_npress", np_a - p0, 0);
        chkn("rstpw_nrel",   nr_a - r0, 0);
        chk1("rstpw_value_after", value_a, 1'b0);

        // Reset while pressed drops the level at once; held key re-debounced.
        key_a = 1'b1;
        tick(7);
        chk1("rstp_pressed", value_a, 1'b1);
        #3 sys_rst_n = 1'b0;
        #1;
        chk1("rstp_async_value", value_a, 1'b0);
        chk1("rstp_async_press", press_a, 1'b0);
        tick(1);
        sys_rst_n = 1'b1;
        tick(6);
        chk1("rstp_e6_value", value_a, 1'b0);
        chk1("rstp_e6_press", press_a, 1'b0);
        tick(1);
        chk1("rstp_e7_press", press_a, 1'b1);
        chk1("rstp_e7_value", value_a, 1'b1);
        tick(1);
        chk1("rstp_e8_press", press_a, 1'b0);
        key_a = 1'b0;
        tick(10);

        chkn("strobe_invariants", viol, 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
